operand_stack: RTL
==================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning maximum number of 32-bit stack entries (power of two, at least 4).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports push_valid (input, 1), push_data (input, 32), push_ready (output, 1): push request.
REQ-005 SHALL have ports pop_valid (input, 1), pop_ready (output, 1), pop_data (output, 32): pop request; pop_data is the current top of stack.
REQ-006 SHALL have ports op_valid (input, 1), op_code (input, 4), op_ready (output, 1): ALU operation request.
REQ-007 SHALL have ports alu_a (output, 32), alu_b (output, 32), alu_sel (output, 4), alu_result (input, 32): to and from the combinational ALU.
REQ-008 SHALL have ports depth (output, $clog2(DEPTH)+1), empty (output, 1), full (output, 1).

Function
REQ-009 SHALL implement an FSM with three states. IDLE accepts commands. EXEC drives the ALU and registers alu_result. WB writes the result back and adjusts the stack pointer, then returns to IDLE.
REQ-010 SHALL accept at most one command per cycle, and only in IDLE. Priority order is op, then pop, then push. The ready output of every lower-priority request SHALL be low while a higher-priority valid is asserted.
REQ-011 SHALL complete a transfer on the clock edge where valid and ready are both high. Push and pop take effect in that same cycle.
REQ-012 SHALL deassert op_ready, pop_ready and push_ready throughout EXEC and WB.
REQ-013 SHALL classify operations using package opcodes. Binary ops are IADD, ISUB, IMUL, IDIV, IREM, IAND, IOR, IXOR, ISHL and ISHR. The unary op is INEG. Every other code is illegal.
REQ-014 SHALL drive operands for a binary op as alu_a = entry below top and alu_b = top, so the result is value1 op value2. For INEG, alu_a = top and alu_b = 0.
REQ-015 SHALL hold alu_a, alu_b and alu_sel stable for the whole EXEC cycle. In IDLE it SHALL drive them to zero.
REQ-016 SHALL have an op latency of 2 cycles from acceptance to the result being visible on pop_data. A binary op reduces depth by one; a unary op leaves depth unchanged.
REQ-017 SHALL raise push_ready only when not full. Push when full is impossible by construction.
REQ-018 SHALL raise pop_ready only when not empty.
REQ-019 SHALL still accept an op on underflow (binary with depth<2, unary with depth<1, or illegal code). In that case it SHALL skip EXEC and WB, leave the stack unchanged, and return op_ready high the next cycle.
REQ-020 SHALL drive pop_data to 0 when empty.
REQ-021 SHALL assert full when depth==DEPTH and empty when depth==0.
REQ-022 SHALL store results into the 32-bit slot unmodified (wrap-around arithmetic belongs to the ALU).

Reset
REQ-023 SHALL, when rst_n is asserted in any state including EXEC or WB, immediately set state=IDLE and depth=0, and discard any in-flight result.
REQ-024 SHALL, during reset, output empty=1, full=0, all ready signals 0, alu_a, alu_b and alu_sel = 0, and pop_data = 0.
REQ-025 SHALL raise the ready signals from the first clock edge after rst_n deasserts. Stack RAM contents need not be reset.

Configuration
REQ-026 SHALL, with STACK_ERR_EN defined, add ports err (output, 1, sticky), err_code (output, 2: 01 underflow, 10 illegal op) and err_clr (input, 1).
REQ-027 SHALL, with STACK_ERR_EN, set err on any underflow or illegal-op acceptance. err_clr SHALL clear it the next cycle, and a simultaneous new error SHALL win over err_clr.
REQ-028 SHALL, without STACK_ERR_EN, omit those ports and drop underflow and illegal ops silently, as in REQ-019.

Structure
REQ-029 SHALL place the opcode constants (IADD=0000, ISUB=0001, IMUL=0010, IDIV=0011, IREM=0100, INEG=0101, ISHL=1100, ISHR=1101, IAND=1111, IOR=1000, IXOR=1001), the FSM state enum and the err_code values in shared package bali_pkg.
REQ-030 SHALL implement storage in sub-module stack_regfile: DEPTH x 32, one synchronous write port and two asynchronous read ports (top, top-1).

Verification
REQ-031 SHALL cover: push 7, push 5, op ISUB -> 2 cycles later pop_data=2, depth=1.
REQ-032 SHALL cover: push 0xFFFFFFFF, push 1, op IADD -> pop_data=0, depth=1.
REQ-033 SHALL cover: push 16 values 0..15 with DEPTH=16 -> full=1, push_ready=0; one pop returns 15, then full=0.
REQ-034 SHALL cover: push 3 only, op IADD -> stack unchanged (depth=1, pop_data=3); with STACK_ERR_EN, err=1 and err_code=01.
REQ-035 SHALL cover: op_valid, pop_valid and push_valid all asserted in the same cycle -> only the op is accepted; pop_ready=0 and push_ready=0.
REQ-036 SHALL cover: rst_n asserted during EXEC of an IMUL -> depth=0, empty=1, state IDLE, no result written.

Source files
------------

// File: rtl/bali_pkg.sv
// Shared opcodes, controller states and error codes for the operand stack.
package bali_pkg;

    localparam logic [3:0] IADD = 4'b0000;
    localparam logic [3:0] ISUB = 4'b0001;
    localparam logic [3:0] IMUL = 4'b0010;
    localparam logic [3:0] IDIV = 4'b0011;
    localparam logic [3:0] IREM = 4'b0100;
    localparam logic [3:0] INEG = 4'b0101;
    localparam logic [3:0] IOR  = 4'b1000;
    localparam logic [3:0] IXOR = 4'b1001;
    localparam logic [3:0] ISHL = 4'b1100;
    localparam logic [3:0] ISHR = 4'b1101;
    localparam logic [3:0] IAND = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b10;

    function automatic logic is_binary(input logic [3:0] op);
        case (op)
            IADD, ISUB, IMUL, IDIV, IREM,
            IAND, IOR, IXOR, ISHL, ISHR: is_binary = 1'b1;
            default:                     is_binary = 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [3:0] op);
        is_unary = (op == INEG);
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: one synchronous write port, asynchronous reads of top and top-1.
module stack_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] top_addr,
    input  logic [AW-1:0] next_addr,
    output logic [31:0]   top_data,
    output logic [31:0]   next_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign top_data  = mem[top_addr];
    assign next_data = mem[next_addr];

endmodule

// File: rtl/operand_stack.sv
// Operand stack with an IDLE/EXEC/WB controller driving an external ALU.
// Define STACK_ERR_EN to add the sticky err/err_code/err_clr ports.
module operand_stack
    import bali_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [31:0]              push_data,
    output logic                     push_ready,
    input  logic                     pop_valid,
    output logic                     pop_ready,
    output logic [31:0]              pop_data,
    input  logic                     op_valid,
    input  logic [3:0]               op_code,
    output logic                     op_ready,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [3:0]               alu_sel,
    input  logic [31:0]              alu_result,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
`ifdef STACK_ERR_EN
    output logic                     full,
    output logic                     err,
    output logic [1:0]               err_code,
    input  logic                     err_clr
`else
    output logic                     full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [31:0]   alu_a_q, alu_a_d;
    logic [31:0]   alu_b_q, alu_b_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [31:0]   result_q, result_d;
    logic          unary_q, unary_d;
    logic          run_q;

    logic          idle;
    logic          op_fire, op_bin, op_un, op_underflow, op_illegal, op_go;
    logic          we;
    logic [AW-1:0] waddr, top_idx, next_idx;
    logic [31:0]   wdata, top_data, next_data;

    stack_regfile #(.DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk       (clk),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .top_addr  (top_idx),
        .next_addr (next_idx),
        .top_data  (top_data),
        .next_data (next_data)
    );

    assign top_idx  = AW'(depth_q - DW'(1));
    assign next_idx = AW'(depth_q - DW'(2));

    // run_q holds the handshakes low during reset and releases them on the first edge after.
    assign idle       = run_q && (state_q == ST_IDLE);
    assign empty      = (depth_q == '0);
    assign full       = (depth_q == DW'(DEPTH));
    assign op_ready   = idle;
    assign pop_ready  = idle && !empty && !op_valid;
    assign push_ready = idle && !full && !op_valid && !pop_valid;
    assign pop_data   = empty ? 32'd0 : top_data;
    assign depth      = depth_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;

    assign op_fire      = op_valid && op_ready;
    assign op_bin       = is_binary(op_code);
    assign op_un        = is_unary(op_code);
    assign op_illegal   = !op_bin && !op_un;
    assign op_underflow = (op_bin && (depth_q < DW'(2))) || (op_un && empty);
    assign op_go        = op_fire && !op_underflow && !op_illegal;

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_sel_d = '0;
        result_d  = result_q;
        unary_d   = unary_q;
        we        = 1'b0;
        waddr     = top_idx;
        wdata     = '0;
        case (state_q)
            ST_IDLE: begin
                if (op_go) begin
                    state_d   = ST_EXEC;
                    unary_d   = op_un;
                    alu_sel_d = op_code;
                    alu_a_d   = op_un ? top_data : next_data;
                    alu_b_d   = op_un ? 32'd0 : top_data;
                end else if (pop_valid && pop_ready) begin
                    depth_d = depth_q - DW'(1);
                end else if (push_valid && push_ready) begin
                    we      = 1'b1;
                    waddr   = AW'(depth_q);
                    wdata   = push_data;
                    depth_d = depth_q + DW'(1);
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_WB;
            end
            ST_WB: begin
                // Binary result overwrites value1 and the top slot is released.
                we    = 1'b1;
                wdata = result_q;
                waddr = unary_q ? top_idx : next_idx;
                if (!unary_q) begin
                    depth_d = depth_q - DW'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            depth_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            result_q  <= '0;
            unary_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
            unary_q   <= unary_d;
            run_q     <= 1'b1;
        end
    end

`ifdef STACK_ERR_EN
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (op_fire && (op_underflow || op_illegal)) begin
            err_d      = 1'b1;
            err_code_d = op_illegal ? ERR_ILLEGAL : ERR_UNDERFLOW;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`endif

endmodule
